// File: rtl/lsu_mem_unit.sv
// Load/store unit between the execute stage and a variable-latency data memory.
// Handles byte lanes, write masks and load extension. A misaligned access that
// crosses a bus word is split into two beats, or rejected with rsp_err when
// splitting is disabled. One bus beat is outstanding at a time.
module lsu_mem_unit #(
  parameter int unsigned XLEN           = 64,
  parameter int unsigned AW             = 64,
  parameter bit          MISALIGN_SPLIT = 1'b1
) (
  input  logic              clk,
  input  logic              rstn,
  // core side
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_op,
  input  logic [AW-1:0]     req_addr,
  input  logic [XLEN-1:0]   req_wdata,
  output logic              rsp_valid,
  output logic [XLEN-1:0]   rsp_rdata,
  output logic              rsp_err,
  // memory side
  output logic              mem_req,
  input  logic              mem_gnt,
  output logic              mem_we,
  output logic [AW-1:0]     mem_addr,
  output logic [XLEN-1:0]   mem_wdata,
  output logic [XLEN/8-1:0] mem_wmask,
  input  logic              mem_rvalid,
  input  logic [XLEN-1:0]   mem_rdata
);

  localparam int unsigned BYTES = XLEN / 8;
  localparam int unsigned OW    = $clog2(BYTES);

  typedef enum logic [2:0] {
    StIdle,
    StReq0,
    StWait0,
    StReq1,
    StWait1,
    StResp
  } state_e;

  state_e state_q, state_d;

  // Latched request
  logic            we_q;
  logic [2:0]      op_q;
  logic [AW-1:0]   addr_q;
  logic [XLEN-1:0] wdata_q;
  logic            cross_q;
  logic [XLEN-1:0] beat0_q;

  logic            rsp_valid_q;
  logic            rsp_err_q;
  logic [XLEN-1:0] rsp_rdata_q;

  // Incoming request decode
  logic [3:0]      req_size;
  logic [OW-1:0]   req_off;
  logic            req_illegal;
  logic            req_cross;
  logic            req_reject;

  // Latched request decode
  logic [3:0]          size;
  logic [OW-1:0]       off;
  logic [2*BYTES-1:0]  lane_mask;
  logic [2*XLEN-1:0]   lane_data;
  logic [AW-1:0]       base_addr;
  logic [XLEN-1:0]     word0;
  logic [XLEN-1:0]     word1;
  logic [XLEN-1:0]     raw;
  logic [XLEN-1:0]     shl;
  logic [XLEN-1:0]     load_ext;
  int unsigned         nbits;
  int unsigned         sh;

  // Classify the request presented on the core port
  always_comb begin
    req_size    = 4'd1 << req_op[1:0];
    req_off     = req_addr[OW-1:0];
    req_illegal = (req_op == 3'b111) ||
                  ((XLEN == 32) && ((req_op[1:0] == 2'b11) || (req_op == 3'b110)));
    req_cross   = (32'(req_off) + 32'(req_size)) > BYTES;
    req_reject  = req_illegal || (req_cross && !MISALIGN_SPLIT);
  end

  // Lane placement of the latched access across the two possible beats
  always_comb begin
    size      = 4'd1 << op_q[1:0];
    off       = addr_q[OW-1:0];
    lane_mask = '0;
    for (int i = 0; i < int'(BYTES); i++) begin
      if (4'(i) < size) lane_mask[i] = 1'b1;
    end
    lane_mask = lane_mask << off;
    // Upper half of the double-wide shift is exactly the beat-1 portion
    lane_data = {{XLEN{1'b0}}, wdata_q} << {off, 3'b000};
    base_addr = addr_q & ~AW'(BYTES - 1);
  end

  // Assemble load bytes from the captured and in-flight beats, then extend
  always_comb begin
    word0 = (state_q == StWait0) ? mem_rdata : beat0_q;
    word1 = (state_q == StWait1) ? mem_rdata : '0;
    raw   = XLEN'({word1, word0} >> {off, 3'b000});
    nbits = 32'd8 << op_q[1:0];
    sh    = (nbits >= XLEN) ? 32'd0 : (XLEN - nbits);
    shl   = raw << sh;
    if (op_q[2]) load_ext = shl >> sh;
    else         load_ext = $unsigned($signed(shl) >>> sh);
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (req_valid) state_d = req_reject ? StResp : StReq0;
      StReq0:  if (mem_gnt) state_d = StWait0;
      StWait0: if (mem_rvalid) state_d = cross_q ? StReq1 : StResp;
      StReq1:  if (mem_gnt) state_d = StWait1;
      StWait1: if (mem_rvalid) state_d = StResp;
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Bus outputs are decoded from state and latched fields so they hold while stalled
  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_wmask = '0;
    if (state_q == StReq0) begin
      mem_req   = 1'b1;
      mem_we    = we_q;
      mem_addr  = base_addr;
      mem_wdata = lane_data[XLEN-1:0];
      mem_wmask = we_q ? lane_mask[BYTES-1:0] : '0;
    end else if (state_q == StReq1) begin
      mem_req   = 1'b1;
      mem_we    = we_q;
      mem_addr  = base_addr + AW'(BYTES);
      mem_wdata = lane_data[2*XLEN-1:XLEN];
      mem_wmask = we_q ? lane_mask[2*BYTES-1:BYTES] : '0;
    end
  end

  // State, request latch, beat capture and registered response
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= StIdle;
      we_q        <= 1'b0;
      op_q        <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      cross_q     <= 1'b0;
      beat0_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state_q <= state_d;
      if ((state_q == StIdle) && req_valid) begin
        we_q    <= req_we;
        op_q    <= req_op;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        cross_q <= req_cross;
      end
      if ((state_q == StWait0) && mem_rvalid) beat0_q <= mem_rdata;
      rsp_valid_q <= (state_d == StResp);
      rsp_err_q   <= (state_q == StIdle) && (state_d == StResp);
      rsp_rdata_q <= ((state_d == StResp) && (state_q != StIdle) && !we_q) ? load_ext : '0;
    end
  end

  assign req_ready = (state_q == StIdle);
  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_lsu_mem_unit.sv
// Bench for lsu_mem_unit: a delay-configurable bus responder plus a byte-level
// reference memory. A second instance with splitting disabled shares the core-side
// request wires and sees an always-ready bus.
module tb_lsu_mem_unit;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  logic        req_valid, req_we, req_ready, rsp_valid, rsp_err;
  logic [2:0]  req_op;
  logic [63:0] req_addr, req_wdata, rsp_rdata;
  logic        mem_req, mem_gnt, mem_we, mem_rvalid;
  logic [63:0] mem_addr, mem_wdata, mem_rdata;
  logic [7:0]  mem_wmask;

  logic        ns_req_ready, ns_rsp_valid, ns_rsp_err, ns_mem_req, ns_mem_we;
  logic [63:0] ns_rsp_rdata, ns_mem_addr, ns_mem_wdata, ns_mem_rdata;
  logic [7:0]  ns_mem_wmask;
  logic        ns_mem_gnt, ns_mem_rvalid;

  lsu_mem_unit #(.XLEN(64), .AW(64), .MISALIGN_SPLIT(1'b1)) dut (
    .clk(clk), .rstn(rstn),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_op(req_op),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_req(mem_req), .mem_gnt(mem_gnt), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wmask(mem_wmask), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata)
  );

  lsu_mem_unit #(.XLEN(64), .AW(64), .MISALIGN_SPLIT(1'b0)) dut_ns (
    .clk(clk), .rstn(rstn),
    .req_valid(req_valid), .req_ready(ns_req_ready), .req_we(req_we), .req_op(req_op),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(ns_rsp_valid), .rsp_rdata(ns_rsp_rdata), .rsp_err(ns_rsp_err),
    .mem_req(ns_mem_req), .mem_gnt(ns_mem_gnt), .mem_we(ns_mem_we), .mem_addr(ns_mem_addr),
    .mem_wdata(ns_mem_wdata), .mem_wmask(ns_mem_wmask), .mem_rvalid(ns_mem_rvalid),
    .mem_rdata(ns_mem_rdata)
  );

  int errors = 0;
  int checks = 0;

  // Bus environment state
  logic [63:0] bus_mem [logic [63:0]];
  logic [7:0]  ref_mem [logic [63:0]];
  int          gnt_delay = 0;
  int          rv_delay  = 0;
  int          stable_bad = 0;
  logic [63:0] log_addr [$];
  logic [63:0] log_wdata [$];
  logic [7:0]  log_mask [$];
  logic        log_we [$];
  bit          ns_req_seen = 1'b0;

  always @(posedge clk) if (ns_mem_req) ns_req_seen <= 1'b1;

  initial begin
    ns_mem_gnt = 1'b1;
    ns_mem_rvalid = 1'b1;
    ns_mem_rdata = '0;
  end

  // Responder: grants after gnt_delay request cycles, answers rv_delay cycles later
  initial begin : responder
    int          gnt_cnt;
    int          rv_cnt;
    bit          rv_pending;
    bit          in_req;
    logic [63:0] rv_data, w, s_addr, s_wdata;
    logic [7:0]  s_mask;
    logic        s_we;
    gnt_cnt = 0; rv_cnt = 0; rv_pending = 0; in_req = 0; rv_data = '0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    forever begin
      @(negedge clk);
      mem_gnt = 1'b0;
      mem_rvalid = 1'b0;
      if (!rstn) begin
        gnt_cnt = 0;
        in_req = 0;
      end
      if (rv_pending) begin
        if (rv_cnt == 0) begin
          mem_rvalid = 1'b1;
          mem_rdata = rv_data;
          rv_pending = 0;
        end else rv_cnt--;
      end else if (mem_req && rstn) begin
        if (!in_req) begin
          in_req = 1; s_addr = mem_addr; s_wdata = mem_wdata; s_mask = mem_wmask; s_we = mem_we;
        end else if (s_addr !== mem_addr || s_wdata !== mem_wdata || s_mask !== mem_wmask ||
                     s_we !== mem_we) begin
          stable_bad++;
        end
        if (gnt_cnt < gnt_delay) gnt_cnt++;
        else begin
          mem_gnt = 1'b1;
          gnt_cnt = 0;
          in_req = 0;
          log_addr.push_back(mem_addr); log_wdata.push_back(mem_wdata);
          log_mask.push_back(mem_wmask); log_we.push_back(mem_we);
          w = bus_mem.exists(mem_addr) ? bus_mem[mem_addr] : 64'h0;
          if (mem_we) begin
            for (int b = 0; b < 8; b++) if (mem_wmask[b]) w[8*b +: 8] = mem_wdata[8*b +: 8];
            bus_mem[mem_addr] = w;
            rv_data = '0;
          end else rv_data = w;
          rv_pending = 1;
          rv_cnt = rv_delay;
        end
      end
    end
  end

  // Reference model: flat byte memory, little-endian, extension by funct3
  function automatic logic [7:0] ref_byte(input logic [63:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : 8'h00;
  endfunction

  function automatic logic [63:0] ref_read(input logic [63:0] addr, input logic [2:0] op);
    logic [63:0] v;
    int n;
    n = 1 << op[1:0];
    v = '0;
    for (int i = 0; i < n; i++) v[8*i +: 8] = ref_byte(addr + 64'(i));
    case (op)
      3'b000:  v = {{56{v[7]}}, v[7:0]};
      3'b001:  v = {{48{v[15]}}, v[15:0]};
      3'b010:  v = {{32{v[31]}}, v[31:0]};
      default: ;
    endcase
    return v;
  endfunction

  task automatic ref_write(input logic [63:0] addr, input logic [2:0] op, input logic [63:0] d);
    int n;
    n = 1 << op[1:0];
    for (int i = 0; i < n; i++) ref_mem[addr + 64'(i)] = d[8*i +: 8];
  endtask

  task automatic init_word(input logic [63:0] a, input logic [63:0] v);
    bus_mem[a] = v;
    for (int i = 0; i < 8; i++) ref_mem[a + 64'(i)] = v[8*i +: 8];
  endtask

  function automatic int exp_beats(input logic [63:0] addr, input logic [2:0] op);
    return (int'(addr % 8) + (1 << op[1:0]) > 8) ? 2 : 1;
  endfunction

  // Issue one request and wait (bounded) for its response; lat = -1 on timeout
  task automatic access(input logic we, input logic [2:0] op, input logic [63:0] addr,
                        input logic [63:0] wd, output logic [63:0] rd, output logic er,
                        output int lat, output bit rdy_low, output bit single);
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_op = op; req_addr = addr; req_wdata = wd;
    @(posedge clk);
    #1 req_valid = 1'b0;
    rd = '0; er = 1'b0; lat = 0; rdy_low = 1; single = 1;
    forever begin
      @(negedge clk);
      lat++;
      if (rsp_valid) break;
      if (req_ready) rdy_low = 0;
      if (lat >= 300) break;
    end
    if (rsp_valid) begin
      rd = rsp_rdata;
      er = rsp_err;
    end else lat = -1;
    @(negedge clk);
    if (rsp_valid) single = 0;
  endtask

  task automatic test_reset();
    #12;
    checks++;
    if (mem_req !== 1'b0 || mem_we !== 1'b0 || rsp_valid !== 1'b0 || rsp_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl: mem_req=%b mem_we=%b rsp_valid=%b rsp_err=%b, want 0 0 0 0",
               mem_req, mem_we, rsp_valid, rsp_err);
    end
    checks++;
    if (rsp_rdata !== 64'h0 || mem_addr !== 64'h0 || mem_wdata !== 64'h0 || mem_wmask !== 8'h0)
    begin
      errors++;
      $display("FAIL reset_data: rdata=%h addr=%h wdata=%h mask=%h, want all 0",
               rsp_rdata, mem_addr, mem_wdata, mem_wmask);
    end
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready: req_ready=%b want 1", req_ready);
    end
  endtask

  task automatic test_loads();
    logic [63:0] rd; logic er; int lat, n0; bit rl, sg;
    logic [63:0] exp_rd [5] = '{64'hFFFFFFFFFFFFFF88, 64'h88, 64'h8877665544332211,
                                64'h0000000009088877, 64'h888};
    logic [2:0]  ops [5] = '{3'b000, 3'b100, 3'b011, 3'b010, 3'b001};
    logic [63:0] adr [5] = '{64'h1007, 64'h1007, 64'h1000, 64'h1006, 64'h1007};
    int          lats [5] = '{3, 3, 3, 5, 5};
    for (int k = 0; k < 5; k++) begin
      n0 = log_addr.size();
      access(1'b0, ops[k], adr[k], 64'h0, rd, er, lat, rl, sg);
      checks++;
      if (rd !== exp_rd[k] || er !== 1'b0 || lat != lats[k] || !sg) begin
        errors++;
        $display("FAIL load_%0d: rdata=%h err=%b lat=%0d single=%0b, want %h 0 %0d 1",
                 k, rd, er, lat, sg, exp_rd[k], lats[k]);
      end
      if (k == 3) begin
        checks++;
        if (log_addr.size() != n0 + 2 || log_addr[n0] !== 64'h1000 ||
            log_addr[n0+1] !== 64'h1008 || log_we[n0] !== 1'b0 || log_mask[n0+1] !== 8'h0) begin
          errors++;
          $display("FAIL lw_split_beats: nbeats=%0d, want 2 beats at 1000/1008 read-only",
                   log_addr.size() - n0);
        end
      end
    end
  endtask

  task automatic test_no_split();
    logic [63:0] rd; logic er; int lat, k; bit rl, sg;
    ns_req_seen = 1'b0;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_op = 3'b010; req_addr = 64'h1006; req_wdata = '0;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (ns_rsp_valid !== 1'b1 || ns_rsp_err !== 1'b1 || ns_rsp_rdata !== 64'h0) begin
      errors++;
      $display("FAIL nosplit_err: valid=%b err=%b rdata=%h, want 1 1 0",
               ns_rsp_valid, ns_rsp_err, ns_rsp_rdata);
    end
    @(negedge clk);
    checks++;
    if (ns_rsp_valid !== 1'b0 || ns_req_seen) begin
      errors++;
      $display("FAIL nosplit_bus: valid=%b mem_req_seen=%0b, want 0 0", ns_rsp_valid, ns_req_seen);
    end
    k = 0;
    while (!rsp_valid && k < 50) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (rsp_valid !== 1'b1 || rsp_rdata !== ref_read(64'h1006, 3'b010) || rsp_err !== 1'b0) begin
      errors++;
      $display("FAIL split_side_lw: valid=%b rdata=%h err=%b, want 1 %h 0",
               rsp_valid, rsp_rdata, rsp_err, ref_read(64'h1006, 3'b010));
    end
    access(1'b0, 3'b111, 64'h1000, 64'h0, rd, er, lat, rl, sg);
    checks++;
    if (er !== 1'b1 || rd !== 64'h0 || lat != 1) begin
      errors++;
      $display("FAIL op111_err: err=%b rdata=%h lat=%0d, want 1 0 1", er, rd, lat);
    end
  endtask

  task automatic test_reset_mid();
    logic [63:0] rd; logic er; int lat, n0, k; bit rl, sg, bad, saw;
    gnt_delay = 0; rv_delay = 8;
    n0 = log_addr.size();
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_op = 3'b010; req_addr = 64'h1006;
    @(posedge clk);
    #1 req_valid = 1'b0;
    k = 0;
    while (log_addr.size() < n0 + 2 && k < 60) begin
      @(negedge clk);
      k++;
    end
    @(posedge clk);
    #2 rstn = 1'b0;
    #1;
    checks++;
    if (mem_req !== 1'b0 || rsp_valid !== 1'b0 || req_ready !== 1'b1 || k >= 60) begin
      errors++;
      $display("FAIL reset_mid: mem_req=%b rsp_valid=%b ready=%b waited=%0d, want 0 0 1 <60",
               mem_req, rsp_valid, req_ready, k);
    end
    bad = 0;
    repeat (2) begin
      @(negedge clk);
      if (rsp_valid !== 1'b0 || mem_req !== 1'b0) bad = 1;
    end
    rstn = 1'b1;
    saw = 0;
    repeat (15) begin
      @(negedge clk);
      if (rsp_valid !== 1'b0 || mem_req !== 1'b0) saw = 1;
    end
    checks++;
    if (bad || saw || req_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_stray: during=%0b after=%0b ready=%b, want 0 0 1", bad, saw, req_ready);
    end
    rv_delay = 0;
    access(1'b0, 3'b011, 64'h1008, 64'h0, rd, er, lat, rl, sg);
    checks++;
    if (rd !== 64'h0F0E0D0C0B0A0908 || er !== 1'b0 || lat != 3) begin
      errors++;
      $display("FAIL reset_next_ld: rdata=%h err=%b lat=%0d, want 0f0e0d0c0b0a0908 0 3",
               rd, er, lat);
    end
  endtask

  task automatic test_store_split();
    logic [63:0] rd; logic er; int lat, n0; bit rl, sg;
    n0 = log_addr.size();
    access(1'b1, 3'b010, 64'h1006, 64'hDEADBEEF, rd, er, lat, rl, sg);
    ref_write(64'h1006, 3'b010, 64'hDEADBEEF);
    checks++;
    if (log_addr.size() != n0 + 2 || er !== 1'b0 || rd !== 64'h0 || lat != 5) begin
      errors++;
      $display("FAIL sw_split_rsp: nbeats=%0d err=%b rdata=%h lat=%0d, want 2 0 0 5",
               log_addr.size() - n0, er, rd, lat);
    end else begin
      checks++;
      if (log_addr[n0] !== 64'h1000 || log_mask[n0] !== 8'hC0 ||
          log_wdata[n0] !== 64'hBEEF000000000000 || log_we[n0] !== 1'b1) begin
        errors++;
        $display("FAIL sw_beat0: addr=%h mask=%h wdata=%h we=%b, want 1000 c0 beef000000000000 1",
                 log_addr[n0], log_mask[n0], log_wdata[n0], log_we[n0]);
      end
      checks++;
      if (log_addr[n0+1] !== 64'h1008 || log_mask[n0+1] !== 8'h03 ||
          log_wdata[n0+1] !== 64'hDEAD || log_we[n0+1] !== 1'b1) begin
        errors++;
        $display("FAIL sw_beat1: addr=%h mask=%h wdata=%h we=%b, want 1008 03 dead 1",
                 log_addr[n0+1], log_mask[n0+1], log_wdata[n0+1], log_we[n0+1]);
      end
    end
    access(1'b0, 3'b010, 64'h1006, 64'h0, rd, er, lat, rl, sg);
    checks++;
    if (rd !== 64'hFFFFFFFFDEADBEEF || er !== 1'b0) begin
      errors++;
      $display("FAIL sw_readback: rdata=%h err=%b, want ffffffffdeadbeef 0", rd, er);
    end
  endtask

  task automatic test_stall();
    logic [63:0] rd; logic er; int lat, sb0; bit rl, sg;
    gnt_delay = 5; rv_delay = 4;
    sb0 = stable_bad;
    access(1'b0, 3'b011, 64'h1000, 64'h0, rd, er, lat, rl, sg);
    checks++;
    if (rd !== ref_read(64'h1000, 3'b011) || lat != 12 || !sg || !rl || stable_bad != sb0) begin
      errors++;
      $display("FAIL stall: rdata=%h lat=%0d single=%0b ready_low=%0b unstable=%0d, want %h 12 1 1 0",
               rd, lat, sg, rl, stable_bad - sb0, ref_read(64'h1000, 3'b011));
    end
    gnt_delay = 0; rv_delay = 0;
  endtask

  task automatic test_wrap();
    logic [63:0] rd; logic er; int lat, n0; bit rl, sg;
    init_word(64'hFFFFFFFFFFFFFFF8, 64'h1122334455667788);
    init_word(64'h0, 64'hA1B2C3D4E5F60718);
    n0 = log_addr.size();
    access(1'b0, 3'b010, 64'hFFFFFFFFFFFFFFFE, 64'h0, rd, er, lat, rl, sg);
    checks++;
    if (rd !== 64'h0000000007181122 || log_addr.size() != n0 + 2 ||
        log_addr[n0] !== 64'hFFFFFFFFFFFFFFF8 || log_addr[n0+1] !== 64'h0) begin
      errors++;
      $display("FAIL wrap: rdata=%h nbeats=%0d, want 0000000007181122 2 (beat1 at 0)",
               rd, log_addr.size() - n0);
    end
  endtask

  task automatic test_random();
    logic [63:0] rd, addr, wd, exp; logic er, we, exp_er; logic [2:0] op;
    int lat, n0, nb, elat; bit rl, sg;
    for (int it = 0; it < 80; it++) begin
      gnt_delay = $urandom_range(0, 2);
      rv_delay  = $urandom_range(0, 2);
      we   = 1'($urandom_range(0, 1));
      op   = 3'($urandom_range(0, 7));
      if (we && op != 3'b111) op = {1'b0, op[1:0]};
      addr = 64'h1000 + 64'($urandom_range(0, 47));
      wd   = {$urandom, $urandom};
      exp_er = (op == 3'b111);
      exp  = (we || exp_er) ? 64'h0 : ref_read(addr, op);
      nb   = exp_er ? 0 : exp_beats(addr, op);
      elat = exp_er ? 1 : 1 + nb * (2 + gnt_delay + rv_delay);
      n0 = log_addr.size();
      access(we, op, addr, wd, rd, er, lat, rl, sg);
      if (we && !exp_er) ref_write(addr, op, wd);
      checks++;
      if (rd !== exp || er !== exp_er || lat != elat || log_addr.size() != n0 + nb || !sg) begin
        errors++;
        $display("FAIL rand_%0d we=%b op=%0d addr=%h: rdata=%h err=%b lat=%0d beats=%0d, want %h %b %0d %0d",
                 it, we, op, addr, rd, er, lat, log_addr.size() - n0, exp, exp_er, elat, nb);
      end
    end
    gnt_delay = 0; rv_delay = 0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    req_valid = 1'b0; req_we = 1'b0; req_op = '0; req_addr = '0; req_wdata = '0;
    init_word(64'h1000, 64'h8877665544332211);
    init_word(64'h1008, 64'h0F0E0D0C0B0A0908);
    test_reset();
    test_loads();
    test_no_split();
    test_reset_mid();
    test_store_split();
    test_stall();
    test_wrap();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/lsu_mem_unit.md
# lsu_mem_unit

Parametrised load/store unit that sits between the core's execute stage and a variable-latency data memory, replacing the fixed single-cycle read/write shift path of the single-cycle core. It accepts one RV64I/RV32I load or store per handshake and handles byte lanes, masks and sign extension. A misaligned access that crosses a bus word is split into two bus beats, or reported as an error when splitting is disabled. The core stalls on `req_ready`/`rsp_valid` instead of assuming a zero-wait memory.

## Interface
- `XLEN`, 64: register and bus data width (32 or 64); `BYTES = XLEN/8`
- `AW`, 64: address width
- `MISALIGN_SPLIT`, 1: 1 = split word-crossing accesses into two beats; 0 = flag them with `rsp_err`
- `clk` in 1: single clock, rising edge
- `rstn` in 1: asynchronous, active-low reset
- `req_valid` in 1: core request valid
- `req_ready` out 1: unit can accept a request
- `req_we` in 1: 1 = store, 0 = load
- `req_op` in 3: funct3 (000 B, 001 H, 010 W, 011 D, 100 BU, 101 HU, 110 WU)
- `req_addr` in AW: byte address
- `req_wdata` in XLEN: store data, right-aligned
- `rsp_valid` out 1: one-cycle completion pulse
- `rsp_rdata` out XLEN: load result, extended to XLEN; 0 for stores and errors
- `rsp_err` out 1: misaligned with split disabled, or illegal op (011/110 when XLEN=32, 111 always)
- `mem_req` out 1: bus request; held until granted
- `mem_gnt` in 1: bus accepts the current beat
- `mem_we` out 1: beat is a write
- `mem_addr` out AW: BYTES-aligned beat address
- `mem_wdata` out XLEN: lane-shifted write data
- `mem_wmask` out BYTES: byte write enable
- `mem_rvalid` in 1: beat completion; read data valid for loads, write ack for stores
- `mem_rdata` in XLEN: full bus word

## Operation
- Size = 1/2/4/8 bytes from `req_op[1:0]`. Offset `off = addr % BYTES`. Crossing when `off + size > BYTES`.
- States: IDLE, REQ0, WAIT0, REQ1, WAIT1, RESP.
- IDLE:
  - `req_ready=1`.
  - On `req_valid`, latch all request fields.
  - Illegal op, or crossing with `MISALIGN_SPLIT=0`: go to RESP with err, no bus traffic.
  - Otherwise go to REQ0.
- REQ0:
  - `mem_req=1`, `mem_addr = addr & ~(BYTES-1)`.
  - `mem_wmask = size-mask << off`, truncated to BYTES; 0 on loads.
  - `mem_wdata = wdata << 8*off`.
  - `mem_gnt` moves to WAIT0.
- WAIT0:
  - On `mem_rvalid`, capture the beat-0 bytes.
  - Go to REQ1 if crossing, else RESP.
- REQ1:
  - `mem_addr` = beat-0 address + BYTES, wrapping modulo 2^AW.
  - `mem_wmask` = the remaining low `off+size-BYTES` bytes.
  - `mem_wdata = wdata >> 8*(BYTES-off)`.
  - `mem_gnt` moves to WAIT1.
- WAIT1: on `mem_rvalid`, capture the beat-1 bytes and go to RESP.
- RESP:
  - `rsp_valid=1` for exactly one cycle.
  - `rsp_rdata` = assembled bytes, sign-extended for B/H/W and zero-extended for BU/HU/WU.
  - Return to IDLE.
- `mem_rvalid` is ignored outside WAIT0/WAIT1.
- `mem_req` stays 0 in all states other than REQ0/REQ1.
- Only one beat is outstanding at a time.

## Timing
- Reset (`rstn=0`, asynchronous):
  - state IDLE; `req_ready=1` once `rstn=1`.
  - `mem_req`, `mem_we`, `rsp_valid`, `rsp_err` = 0.
  - `rsp_rdata`, `mem_addr`, `mem_wdata`, `mem_wmask` = 0.
- Reset mid-operation aborts the access: no response is produced, `mem_req` drops immediately, and a late `mem_rvalid` after reset is ignored.
- `req_ready` is a registered-state decode, low from the cycle after acceptance until the cycle after RESP.
- Aligned access with `mem_gnt` in its first cycle and `mem_rvalid` one cycle later:
  - accept at edge 0;
  - `mem_req` in cycle 1;
  - `rvalid` in cycle 2;
  - `rsp_valid` in cycle 3.
- Split access adds 2 cycles. Error path: `rsp_valid` the cycle after acceptance.
- Bus outputs are registered or state-decoded and stable while `mem_req=1 && !mem_gnt`.
- `rsp_*` are registered, valid only while `rsp_valid=1`.

## Test plan
All cases use XLEN=64 and MISALIGN_SPLIT=1 unless stated. Memory holds 0x1000 = 0x8877665544332211 and 0x1008 = 0x0F0E0D0C0B0A0908.
- LB 0x1007 -> `rsp_rdata` 0xFFFFFFFFFFFFFF88. LBU 0x1007 -> 0x88. LD 0x1000 -> 0x8877665544332211, one beat, 3-cycle latency.
- LW 0x1006 -> two beats at 0x1000 then 0x1008; `rsp_rdata` 0x0000000009088877. LH 0x1007 -> 0x888.
- SW 0x1006 data 0xDEADBEEF:
  - beat0: addr 0x1000, mask 0xC0, wdata 0xBEEF000000000000;
  - beat1: addr 0x1008, mask 0x03, wdata 0xDEAD;
  - readback LW 0x1006 -> 0xFFFFFFFFDEADBEEF.
- MISALIGN_SPLIT=0, LW 0x1006 -> no `mem_req`; `rsp_valid` + `rsp_err` one cycle after accept; `rsp_rdata` 0. Also op 111 -> `rsp_err`.
- Withhold `mem_gnt` for 5 cycles and delay `rvalid` by 4 -> bus fields stable while waiting, exactly one `rsp_valid` pulse, `req_ready=0` throughout.
- Assert `rstn=0` during WAIT1 of a split load -> `mem_req=0`, no `rsp_valid`; a stray `mem_rvalid` after release is ignored; the next LD 0x1008 returns 0x0F0E0D0C0B0A0908.
